// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer in front of the 64-bit register file.
// Result writes are queued in a small FIFO and drained one per cycle into the
// registered WriteRegister/WriteData/RegWrite port. Writes to X31 are dropped.
// Two combinational lookups expose pending (not yet committed) values.
// Optional build macro WB_COALESCE_EN: a push to the same register as the
// youngest entry overwrites that entry's data instead of allocating a new one.
module wb_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        fwd_reg1,
  input  logic [ADDR_W-1:0]        fwd_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Hard-wired zero register (X31) is the all-ones index.
  localparam logic [ADDR_W-1:0] ZeroReg = '1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic push_hs, store, pop, coalesce, alloc;

  assign in_ready      = (count_q != CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_reg_q;
  assign WriteData     = write_data_q;

  // Handshake decode, coalesce decision and next-state for pointers/count/output port.
  always_comb begin
    push_hs  = in_valid && in_ready;
    store    = push_hs && (in_reg != ZeroReg);
    pop      = drain_en && !empty;
    coalesce = 1'b0;
`ifdef WB_COALESCE_EN
    begin
      logic [PW-1:0] tail_idx;
      tail_idx = wr_ptr_q - PW'(1);
      // Tail is only safe to overwrite if it is not the entry leaving this cycle.
      coalesce = store && (count_q != '0) && (ent_reg_q[tail_idx] == in_reg) &&
                 !(pop && (count_q == CW'(1)));
    end
`endif
    alloc = store && !coalesce;

    wr_ptr_d     = alloc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(alloc) - CW'(pop);
    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = ent_reg_q[rd_ptr_q];
      write_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // Control state and registered regfile port; reset drops all pending writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Entry storage; validity is implied by count/pointers, so no reset needed here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc) begin
        ent_reg_q[wr_ptr_q]  <= in_reg;
        ent_data_q[wr_ptr_q] <= in_data;
      end else if (coalesce) begin
        ent_data_q[wr_ptr_q - PW'(1)] <= in_data;
      end
    end
  end

  // Forwarding: output register lowest priority, then queue entries oldest to
  // youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    if (reg_write_q && (write_reg_q == fwd_reg1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = write_data_q;
    end
    if (reg_write_q && (write_reg_q == fwd_reg2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = write_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (ent_reg_q[idx] == fwd_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data_q[idx];
        end
        if (ent_reg_q[idx] == fwd_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data_q[idx];
        end
      end
    end
    if (fwd_reg1 == ZeroReg) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (fwd_reg2 == ZeroReg) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_wb_write_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [63:0] in_data;
  logic        drain_en;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        empty;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg       (in_reg),
    .in_data      (in_data),
    .drain_en     (drain_en),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .fwd_reg1     (fwd_reg1),
    .fwd_reg2     (fwd_reg2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the regfile port.
  typedef struct packed {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;
  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [63:0] m_wdata;

  // Last observed DUT values, for directed constant checks between steps.
  logic        o_rw, o_ready, o_hit1, o_hit2;
  logic [4:0]  o_wreg;
  logic [63:0] o_wdata, o_data1, o_data2;
  logic [2:0]  o_count;
  int          rw_seen;

  function automatic void fwd_model(input logic [4:0] r, output logic hit,
                                    output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    if (r == 5'd31) return;
    if (m_rw && m_wreg == r) begin
      hit = 1'b1;
      d   = m_wdata;
    end
    foreach (mq[i]) begin
      if (mq[i].r == r) begin
        hit = 1'b1;
        d   = mq[i].d;
      end
    end
  endfunction

  // One clock cycle: drive inputs, compare every output to the model, advance both.
  task automatic step(input logic v, input logic [4:0] r, input logic [63:0] d,
                      input logic dr, input logic rst, input logic [4:0] f1,
                      input logic [4:0] f2);
    logic        eh1, eh2, pop, push, coal;
    logic [63:0] ed1, ed2;
    int          sz;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; drain_en = dr; reset = rst;
    fwd_reg1 = f1; fwd_reg2 = f2;
    #1;
    fwd_model(f1, eh1, ed1);
    fwd_model(f2, eh2, ed2);
    check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    check("count", 64'(count), 64'(mq.size()));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("RegWrite", 64'(RegWrite), 64'(m_rw));
    check("WriteRegister", 64'(WriteRegister), 64'(m_wreg));
    check("WriteData", WriteData, m_wdata);
    check("fwd_hit1", 64'(fwd_hit1), 64'(eh1));
    check("fwd_data1", fwd_data1, ed1);
    check("fwd_hit2", 64'(fwd_hit2), 64'(eh2));
    check("fwd_data2", fwd_data2, ed2);
    o_rw = RegWrite; o_wreg = WriteRegister; o_wdata = WriteData; o_count = count;
    o_ready = in_ready; o_hit1 = fwd_hit1; o_data1 = fwd_data1;
    o_hit2 = fwd_hit2; o_data2 = fwd_data2;
    if (RegWrite) rw_seen++;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    end else begin
      sz   = mq.size();
      pop  = dr && (sz != 0);
      push = v && (sz != DEPTH) && (r != 5'd31);
      coal = 1'b0;
`ifdef WB_COALESCE_EN
      coal = push && (sz != 0) && (mq[sz-1].r == r) && !(pop && sz == 1);
`endif
      if (coal) mq[sz-1].d = d;
      if (pop) begin
        m_rw    = 1'b1;
        m_wreg  = mq[0].r;
        m_wdata = mq[0].d;
        void'(mq.pop_front());
      end else begin
        m_rw = 1'b0;
      end
      if (push && !coal) mq.push_back('{r: r, d: d});
    end
  endtask

  task automatic idle(input logic dr, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 64'd0, dr, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    in_valid = 0; in_reg = 0; in_data = 0; drain_en = 0; reset = 1;
    fwd_reg1 = 0; fwd_reg2 = 0;
    m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    rw_seen = 0;
    // Bring the DUT to a known state before the model starts comparing.
    repeat (2) @(posedge clk);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 5'd0, 5'd0);

    // Single write: visible on the port two cycles after acceptance.
    step(1'b1, 5'd1, 64'h1111, 1'b1, 1'b0, 5'd1, 5'd2);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd1, 5'd2);
    check("p1_fwd_pending", 64'(o_hit1), 64'd1);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd1, 5'd2);
    check("p1_rw", 64'(o_rw), 64'd1);
    check("p1_wreg", 64'(o_wreg), 64'd1);
    check("p1_wdata", o_wdata, 64'h1111);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd1, 5'd2);
    check("p1_rw_off", 64'(o_rw), 64'd0);
    check("p1_count", 64'(o_count), 64'd0);

    // Fill to full, hold a fifth request, then drain.
    for (int k = 1; k <= 4; k++) step(1'b1, 5'(k), 64'(k * 16), 1'b0, 1'b0, 5'd3, 5'd31);
    step(1'b1, 5'd9, 64'h50, 1'b0, 1'b0, 5'd3, 5'd31);
    check("p2_full_count", 64'(o_count), 64'd4);
    check("p2_full_ready", 64'(o_ready), 64'd0);
    check("p2_fwd3", o_data1, 64'h30);
    step(1'b1, 5'd9, 64'h50, 1'b1, 1'b0, 5'd9, 5'd1);
    step(1'b1, 5'd9, 64'h50, 1'b1, 1'b0, 5'd9, 5'd1);
    check("p2_first_pop_reg", 64'(o_wreg), 64'd1);
    idle(1'b1, 7);

    // Two writes to X5 without draining: youngest data forwards.
    step(1'b1, 5'd5, 64'hA, 1'b0, 1'b0, 5'd5, 5'd6);
    step(1'b1, 5'd5, 64'hB, 1'b0, 1'b0, 5'd5, 5'd6);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd5, 5'd6);
    check("p3_fwd_data1", o_data1, 64'hB);
    check("p3_fwd_hit2", 64'(o_hit2), 64'd0);
    idle(1'b1, 5);

    // X31 writes handshake but are never stored or written.
    rw_seen = 0;
    step(1'b1, 5'd31, 64'hDEAD, 1'b1, 1'b0, 5'd31, 5'd31);
    check("p4_ready", 64'(o_ready), 64'd1);
    idle(1'b1, 3);
    check("p4_count", 64'(o_count), 64'd0);
    check("p4_no_write", 64'(rw_seen), 64'd0);

    // Reset mid-drain throws away everything pending.
    for (int k = 0; k < 3; k++) step(1'b1, 5'(k + 10), 64'(k + 100), 1'b0, 1'b0, 5'd10, 5'd11);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd10, 5'd11);
    step(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 5'd10, 5'd11);
    rw_seen = 0;
    idle(1'b1, 4);
    check("p5_no_write_after_reset", 64'(rw_seen), 64'd0);

`ifdef WB_COALESCE_EN
    // Back-to-back writes to X7 merge into one entry.
    step(1'b1, 5'd7, 64'd1, 1'b0, 1'b0, 5'd7, 5'd0);
    step(1'b1, 5'd7, 64'd2, 1'b0, 1'b0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd7, 5'd0);
    check("p6_count", 64'(o_count), 64'd1);
    check("p6_fwd", o_data1, 64'd2);
    rw_seen = 0;
    idle(1'b1, 4);
    check("p6_single_write", 64'(rw_seen), 64'd1);
`endif

    // Randomized traffic on a small register subset to exercise matches/wrap.
    for (int k = 0; k < 2000; k++) begin
      logic [4:0] r, f1, f2;
      r  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      f1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      f2 = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), r, {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0), f1, f2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback-side producer for the 64-bit register file. It sits between the execute/memory result sources and the regfile write port: WriteRegister, WriteData, RegWrite.
- Buffers result writes in a small in-order FIFO and drains one write per cycle into the regfile.
- Silently discards writes to X31, the hard-wired zero register.
- Offers two combinational forwarding lookups so the read side can see values that are pending but not yet committed.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- DATA_W, 64, result data width.
- ADDR_W, 5, register index width (32 registers, X31 = zero).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a write request.
- in_ready  output  1  queue can accept a request this cycle.
- in_reg  input  ADDR_W  destination register of the request.
- in_data  input  DATA_W  result data of the request.
- drain_en  input  1  permits a pop this cycle; 0 holds the queue.
- RegWrite  output  1  regfile write enable (registered).
- WriteRegister  output  ADDR_W  regfile write index (registered).
- WriteData  output  DATA_W  regfile write data (registered).
- fwd_reg1, fwd_reg2  input  ADDR_W  forwarding lookup indices.
- fwd_hit1, fwd_hit2  output  1  a pending write to fwd_regN exists.
- fwd_data1, fwd_data2  output  DATA_W  youngest pending data for fwd_regN.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- empty  output  1  count == 0.

Behaviour:
- Reset (synchronous, active-high): count=0, read/write pointers=0, RegWrite=0, WriteRegister=0, WriteData=0. All entries are invalidated; a reset mid-operation discards every pending write, and no write issues after reset.
- in_ready = (count != DEPTH), derived from registered state only. It has no combinational path from in_valid.
- Push: occurs when in_valid && in_ready.
  - in_reg != 31: the entry {in_reg, in_data} is written at the tail and count increments.
  - in_reg == 31: the handshake completes, nothing is stored, count is unchanged.
- Pop: occurs when drain_en && !empty.
  - The head entry is loaded into the output registers: RegWrite=1, WriteRegister=head.reg, WriteData=head.data.
  - Otherwise RegWrite=0 and WriteRegister/WriteData hold their previous values.
- Push and pop in the same cycle: both take effect, so count is unchanged. A push into an empty queue cannot be popped in the same cycle (no bypass).
- Latency: a request accepted in cycle N is stored at the end of N, popped at the end of N+1 (if drain_en), and RegWrite is high during cycle N+2.
- Ordering: strictly FIFO. Writes reach the regfile in acceptance order.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by count.
- Forwarding (combinational):
  - Search all valid queue entries plus the output register (when RegWrite=1).
  - Priority is youngest queue entry first, then older queue entries, then the output register.
  - fwd_hitN=1 and fwd_dataN=matched data on a match; otherwise fwd_hitN=0 and fwd_dataN=0.
  - fwd_regN == 31 always gives hit=0, data=0.
- A push in the current cycle is not visible to forwarding until the next cycle.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: when a push targets the same register as the current tail entry (the youngest valid entry), and that entry is not being popped this cycle, the tail data is overwritten in place. No new entry is allocated and count is unchanged. in_ready is unaffected (still !full).
- Undefined: every non-X31 push allocates a new entry.

Test Plan:
1. Reset, drain_en=1, push X1=0x1111 in cycle 0 -> cycle 2: RegWrite=1, WriteRegister=1, WriteData=0x1111; cycle 3: RegWrite=0, count=0.
2. drain_en=0, push X1..X4 with data 0x10..0x40 -> count=4, in_ready=0, a 5th request is held. Then drain_en=1 -> four consecutive RegWrite cycles writing X1..X4 with 0x10..0x40; the held 5th request is accepted the cycle after the first pop.
3. drain_en=0, push X5=0xA then X5=0xB (macro undefined) -> count=2; fwd_reg1=5 gives hit1=1, data1=0xB; fwd_reg2=6 gives hit2=0, data2=0.
4. Push X31=0xDEAD with in_valid=1 -> in_ready=1, count stays 0, RegWrite never asserts; fwd_reg1=31 gives hit1=0, data1=0.
5. Three entries queued, drain_en=1, assert reset for one cycle mid-drain -> next cycle count=0, empty=1, RegWrite=0, and no further writes issue.
6. WB_COALESCE_EN defined, drain_en=0, push X7=1 then X7=2 -> count=1, fwd_data1=2 for fwd_reg1=7; drain gives a single RegWrite of X7=2.
